// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline: MEM-stage control bundle, FSM
// states, reset constants and the big-endian byte-lane helpers.
package mips_pkg;

    localparam int WORD_W = 32;
    localparam int LANES  = WORD_W / 8;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } mem_state_e;

    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
        logic mem_read;
        logic mem_write;
        logic is_byte;
        logic is_unsigned;
    } mem_ctrl_t;

    localparam mem_ctrl_t         CTRL_RST = '0;
    localparam logic [WORD_W-1:0] WORD_RST = '0;
    localparam logic [4:0]        REG_RST  = '0;

    // Big-endian lanes: address offset 0 is the most significant byte.
    function automatic logic [7:0] lane_select(input logic [WORD_W-1:0] word,
                                               input logic [1:0]        lane);
        logic [7:0] b;
        case (lane)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            default: b = word[7:0];
        endcase
        return b;
    endfunction

    function automatic logic [LANES-1:0] byte_enable(input logic       is_byte,
                                                     input logic [1:0] lane);
        logic [LANES-1:0] be;
        if (is_byte) be = 4'b1000 >> lane;
        else         be = 4'b1111;
        return be;
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load data alignment: picks the addressed byte lane of the returned word
// and sign- or zero-extends it; word loads pass through untouched.
module mem_load_align
    import mips_pkg::*;
(
    input  logic [WORD_W-1:0] rdata_i,
    input  logic [1:0]        lane_i,
    input  logic              is_byte_i,
    input  logic              is_unsigned_i,
    output logic [WORD_W-1:0] data_o
);

    logic [7:0] byte_sel;

    always_comb begin
        byte_sel = lane_select(rdata_i, lane_i);
        if (!is_byte_i)         data_o = rdata_i;
        else if (is_unsigned_i) data_o = {24'b0, byte_sel};
        else                    data_o = {{24{byte_sel[7]}}, byte_sel};
    end

endmodule

// File: rtl/mem_stage.sv
// MEM stage of the five-stage MIPS pipeline: EXE/MEM register, data-memory
// access FSM over a req/ack handshake, and the MEM/WB register.
module mem_stage
    import mips_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                Clk,
    input  logic                Rst,
    input  logic [ADDR_W-1:0]   OUT_ALU32,
    input  logic [DATA_W-1:0]   Store_data_EXE,
    input  logic [4:0]          RegWr_EXE,
    input  logic                RegWrite_EXE,
    input  logic                MemtoReg_EXE,
    input  logic                MemRead_EXE,
    input  logic                MemWrite_EXE,
    input  logic                Byte_EXE,
    input  logic                Unsigned_EXE,
    output logic [ADDR_W-1:0]   Adrs_MEM,
    output logic [4:0]          RegWr_MEM,
    output logic                RegWrite_EXE_MEM,
    output logic [DATA_W-1:0]   WB_data,
    output logic [4:0]          RegWr_WB,
    output logic                RegWrite_MEM_WB,
    output logic                Mem_stall,
    output logic                Addr_err,
    output logic                dmem_req,
    output logic                dmem_we,
    output logic [ADDR_W-1:0]   dmem_addr,
    output logic [DATA_W/8-1:0] dmem_be,
    output logic [DATA_W-1:0]   dmem_wdata,
    input  logic [DATA_W-1:0]   dmem_rdata,
    input  logic                dmem_ack,
    output mem_state_e          dbg_state_o
);

    mem_state_e        state_q, state_d;
    logic [ADDR_W-1:0] em_addr_q, em_addr_d;
    logic [DATA_W-1:0] em_sdata_q, em_sdata_d;
    logic [4:0]        em_rd_q, em_rd_d;
    mem_ctrl_t         em_ctrl_q, em_ctrl_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;
    logic [4:0]        wb_rd_q, wb_rd_d;
    logic              wb_we_q, wb_we_d;

    logic              exe_access;
    logic              misaligned;
    logic              in_access;
    logic [DATA_W-1:0] load_data;

    // Handshake: dmem_req stays high with addr/be/we/wdata held from the
    // EXE/MEM register until the cycle dmem_ack=1 (may be the first req
    // cycle); that cycle completes the access. Ack without req is ignored.
    assign exe_access = (MemRead_EXE | MemWrite_EXE) &
                        (Byte_EXE | (OUT_ALU32[1:0] == 2'b00));
    assign misaligned = (em_ctrl_q.mem_read | em_ctrl_q.mem_write) &
                        ~em_ctrl_q.is_byte & (em_addr_q[1:0] != 2'b00);
    assign in_access  = (state_q == ST_ACCESS);
    assign Mem_stall  = in_access & ~dmem_ack;

    mem_load_align u_load_align (
        .rdata_i       (dmem_rdata),
        .lane_i        (em_addr_q[1:0]),
        .is_byte_i     (em_ctrl_q.is_byte),
        .is_unsigned_i (em_ctrl_q.is_unsigned),
        .data_o        (load_data)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   state_d = exe_access ? ST_ACCESS : ST_IDLE;
            ST_ACCESS: if (dmem_ack) state_d = exe_access ? ST_ACCESS : ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        em_addr_d  = em_addr_q;
        em_sdata_d = em_sdata_q;
        em_rd_d    = em_rd_q;
        em_ctrl_d  = em_ctrl_q;
        wb_data_d  = WORD_RST;
        wb_rd_d    = REG_RST;
        wb_we_d    = 1'b0;
        if (!Mem_stall) begin
            em_addr_d  = OUT_ALU32;
            em_sdata_d = Store_data_EXE;
            em_rd_d    = RegWr_EXE;
            em_ctrl_d  = '{reg_write:   RegWrite_EXE,
                           mem_to_reg:  MemtoReg_EXE,
                           mem_read:    MemRead_EXE,
                           mem_write:   MemWrite_EXE,
                           is_byte:     Byte_EXE,
                           is_unsigned: Unsigned_EXE};
            // A stalled cycle leaves the bubble defaults in MEM/WB.
            wb_data_d  = em_ctrl_q.mem_to_reg ? load_data : em_addr_q;
            wb_rd_d    = em_rd_q;
            wb_we_d    = em_ctrl_q.reg_write & ~misaligned;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q    <= ST_IDLE;
            em_addr_q  <= WORD_RST;
            em_sdata_q <= WORD_RST;
            em_rd_q    <= REG_RST;
            em_ctrl_q  <= CTRL_RST;
            wb_data_q  <= WORD_RST;
            wb_rd_q    <= REG_RST;
            wb_we_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            em_addr_q  <= em_addr_d;
            em_sdata_q <= em_sdata_d;
            em_rd_q    <= em_rd_d;
            em_ctrl_q  <= em_ctrl_d;
            wb_data_q  <= wb_data_d;
            wb_rd_q    <= wb_rd_d;
            wb_we_q    <= wb_we_d;
        end
    end

    assign dmem_req   = in_access;
    assign dmem_we    = in_access & em_ctrl_q.mem_write;
    assign dmem_addr  = in_access ? {em_addr_q[ADDR_W-1:2], 2'b00} : '0;
    assign dmem_be    = in_access ? byte_enable(em_ctrl_q.is_byte, em_addr_q[1:0]) : '0;
    assign dmem_wdata = !in_access        ? '0 :
                        em_ctrl_q.is_byte ? {4{em_sdata_q[7:0]}} : em_sdata_q;

    assign Addr_err         = misaligned;
    assign Adrs_MEM         = em_addr_q;
    assign RegWr_MEM        = em_rd_q;
    assign RegWrite_EXE_MEM = em_ctrl_q.reg_write & ~misaligned;
    assign WB_data          = wb_data_q;
    assign RegWr_WB         = wb_rd_q;
    assign RegWrite_MEM_WB  = wb_we_q;
    assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed vector table, random instruction stream
// against a transaction-level model, and a reset-during-access sequence.
module tb_mem_stage;
    import mips_pkg::*;

    logic        Clk = 1'b0;
    logic        Rst;
    logic [31:0] OUT_ALU32, Store_data_EXE, dmem_rdata;
    logic [4:0]  RegWr_EXE;
    logic        RegWrite_EXE, MemtoReg_EXE, MemRead_EXE, MemWrite_EXE, Byte_EXE, Unsigned_EXE;
    logic        dmem_ack;
    logic [31:0] Adrs_MEM, WB_data, dmem_addr, dmem_wdata;
    logic [4:0]  RegWr_MEM, RegWr_WB;
    logic        RegWrite_EXE_MEM, RegWrite_MEM_WB, Mem_stall, Addr_err, dmem_req, dmem_we;
    logic [3:0]  dmem_be;
    mem_state_e  dbg_state;

    mem_stage dut (
        .Clk(Clk), .Rst(Rst), .OUT_ALU32(OUT_ALU32), .Store_data_EXE(Store_data_EXE),
        .RegWr_EXE(RegWr_EXE), .RegWrite_EXE(RegWrite_EXE), .MemtoReg_EXE(MemtoReg_EXE),
        .MemRead_EXE(MemRead_EXE), .MemWrite_EXE(MemWrite_EXE), .Byte_EXE(Byte_EXE),
        .Unsigned_EXE(Unsigned_EXE), .Adrs_MEM(Adrs_MEM), .RegWr_MEM(RegWr_MEM),
        .RegWrite_EXE_MEM(RegWrite_EXE_MEM), .WB_data(WB_data), .RegWr_WB(RegWr_WB),
        .RegWrite_MEM_WB(RegWrite_MEM_WB), .Mem_stall(Mem_stall), .Addr_err(Addr_err),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .dbg_state_o(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 Clk = ~Clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- instruction records ----------------
    typedef struct {
        logic [31:0] alu, sd, rdata;
        logic [4:0]  rd;
        logic        regwrite, memtoreg, mrd, mwr, byt, uns;
        int          wait_n;
        bit          has_exp;
        logic [31:0] e_addr, e_wdata, e_wb;
        logic [3:0]  e_be;
        logic        e_rw, e_err;
    } vec_t;

    // scoreboard entry: {check_data, regwrite, rd, data}
    localparam logic [38:0] BUBBLE = {1'b1, 38'd0};
    logic [38:0] exp_q[$];
    int n_chk = 0;
    int n_fail = 0;
    vec_t tab[11];
    vec_t nop, cur, v;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] alu, input logic [31:0] sd,
                                input logic [4:0] rd, input logic rw, input logic m2r,
                                input logic mrd, input logic mwr, input logic byt,
                                input logic uns, input int wt, input logic [31:0] rdata);
        vec_t r;
        r.alu = alu; r.sd = sd; r.rd = rd; r.regwrite = rw; r.memtoreg = m2r;
        r.mrd = mrd; r.mwr = mwr; r.byt = byt; r.uns = uns; r.wait_n = wt; r.rdata = rdata;
        r.has_exp = 0; r.e_addr = 0; r.e_wdata = 0; r.e_wb = 0; r.e_be = 0;
        r.e_rw = 0; r.e_err = 0;
        return r;
    endfunction

    function automatic vec_t with_exp(input vec_t r, input logic [31:0] addr,
                                      input logic [3:0] be, input logic [31:0] wdata,
                                      input logic [31:0] wb, input logic rw, input logic err);
        vec_t o;
        o = r;
        o.has_exp = 1; o.e_addr = addr; o.e_be = be; o.e_wdata = wdata;
        o.e_wb = wb; o.e_rw = rw; o.e_err = err;
        return o;
    endfunction

    // ---------------- reference model ----------------
    function automatic bit is_mem(input vec_t r);
        return r.mrd || r.mwr;
    endfunction

    function automatic bit is_mis(input vec_t r);
        return is_mem(r) && !r.byt && (r.alu % 4 != 0);
    endfunction

    function automatic bit is_acc(input vec_t r);
        return is_mem(r) && !is_mis(r);
    endfunction

    function automatic logic [31:0] model_load(input vec_t r);
        logic [31:0] b;
        int          sh;
        if (!r.byt) return r.rdata;
        sh = 8 * (3 - int'(r.alu % 4));
        b  = (r.rdata >> sh) & 32'hFF;
        if (!r.uns && b >= 32'h80) b = b + 32'hFFFF_FF00;
        return b;
    endfunction

    function automatic logic [3:0] model_be(input vec_t r);
        return r.byt ? 4'(1 << (3 - int'(r.alu % 4))) : 4'hF;
    endfunction

    function automatic logic [31:0] model_wdata(input vec_t r);
        return r.byt ? (32'(r.sd[7:0]) * 32'h0101_0101) : r.sd;
    endfunction

    function automatic logic [38:0] model_wb(input vec_t r);
        logic [31:0] d;
        logic        we;
        bit          c;
        if (r.has_exp) begin
            d = r.e_wb; we = r.e_rw; c = !r.e_err;
        end else begin
            we = r.regwrite && !is_mis(r);
            d  = r.memtoreg ? model_load(r) : r.alu;
            c  = !is_mis(r);
        end
        return {c, we, r.rd, d};
    endfunction

    // ---------------- drivers ----------------
    task automatic drive_exe(input vec_t r);
        OUT_ALU32 = r.alu; Store_data_EXE = r.sd; RegWr_EXE = r.rd;
        RegWrite_EXE = r.regwrite; MemtoReg_EXE = r.memtoreg; MemRead_EXE = r.mrd;
        MemWrite_EXE = r.mwr; Byte_EXE = r.byt; Unsigned_EXE = r.uns;
    endtask

    task automatic drive_junk();
        OUT_ALU32 = $urandom; Store_data_EXE = $urandom; RegWr_EXE = 5'($urandom_range(0, 31));
        {RegWrite_EXE, MemtoReg_EXE, MemRead_EXE, MemWrite_EXE, Byte_EXE, Unsigned_EXE} =
            6'($urandom_range(0, 63));
    endtask

    function automatic vec_t rand_vec();
        vec_t r;
        int   k;
        r = mk($urandom, $urandom, 5'($urandom_range(0, 31)), 0, 0, 0, 0, 0, 0,
               $urandom_range(0, 3), $urandom);
        k = $urandom_range(0, 4);
        case (k)
            0: r.regwrite = 1'($urandom_range(0, 1));
            1: begin
                r.mrd = 1; r.memtoreg = 1; r.regwrite = 1;
                if ($urandom_range(0, 3) != 0) r.alu[1:0] = 2'b00;
            end
            2: begin
                r.mrd = 1; r.memtoreg = 1; r.regwrite = 1; r.byt = 1;
                r.uns = 1'($urandom_range(0, 1));
            end
            3: begin
                r.mwr = 1;
                if ($urandom_range(0, 3) != 0) r.alu[1:0] = 2'b00;
            end
            default: begin r.mwr = 1; r.byt = 1; end
        endcase
        return r;
    endfunction

    // One instruction's stay in EXE/MEM while the next waits in EXE.
    // Entered and left at posedge+1.
    task automatic step(input vec_t c, input vec_t nxt);
        bit          acc, last, e_err;
        int          nw;
        logic [31:0] e_addr, e_wdata;
        logic [3:0]  e_be;
        logic [38:0] e;
        acc = is_acc(c);
        nw  = acc ? c.wait_n : 0;
        if (c.has_exp) begin
            e_addr = c.e_addr; e_be = c.e_be; e_wdata = c.e_wdata; e_err = c.e_err;
        end else begin
            e_addr = c.alu - (c.alu % 4); e_be = model_be(c);
            e_wdata = model_wdata(c); e_err = is_mis(c);
        end
        for (int w = 0; w <= nw; w++) begin
            last = (w == nw);
            if (last) drive_exe(nxt);
            else      drive_junk();
            dmem_ack   = acc ? last : 1'($urandom_range(0, 1));
            dmem_rdata = last ? c.rdata : $urandom;
            @(negedge Clk);
            chk("mem_stall", 32'(Mem_stall), 32'(acc && !last));
            chk("dmem_req", 32'(dmem_req), 32'(acc));
            chk("state_access", 32'(dbg_state == ST_ACCESS), 32'(acc));
            chk("addr_err", 32'(Addr_err), 32'(e_err));
            chk("fwd_adrs", Adrs_MEM, c.alu);
            chk("fwd_rd", 32'(RegWr_MEM), 32'(c.rd));
            chk("fwd_regwrite", 32'(RegWrite_EXE_MEM), 32'(c.regwrite && !e_err));
            if (acc) begin
                chk("dmem_addr", dmem_addr, e_addr);
                chk("dmem_be", 32'(dmem_be), 32'(e_be));
                chk("dmem_we", 32'(dmem_we), 32'(c.mwr));
                if (c.mwr) chk("dmem_wdata", dmem_wdata, e_wdata);
            end
            if (exp_q.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL scoreboard: got empty queue expected an entry at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                chk("wb_regwrite", 32'(RegWrite_MEM_WB), 32'(e[37]));
                chk("wb_rd", 32'(RegWr_WB), 32'(e[36:32]));
                if (e[38]) chk("wb_data", WB_data, e[31:0]);
            end
            exp_q.push_back(last ? model_wb(c) : BUBBLE);
            @(posedge Clk); #1;
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_stall"}, 32'(Mem_stall), 0);
        chk({tag, "_req"}, 32'(dmem_req), 0);
        chk({tag, "_we"}, 32'(dmem_we), 0);
        chk({tag, "_be"}, 32'(dmem_be), 0);
        chk({tag, "_addr_err"}, 32'(Addr_err), 0);
        chk({tag, "_wb_data"}, WB_data, 0);
        chk({tag, "_wb_rd"}, 32'(RegWr_WB), 0);
        chk({tag, "_wb_regwrite"}, 32'(RegWrite_MEM_WB), 0);
        chk({tag, "_fwd_regwrite"}, 32'(RegWrite_EXE_MEM), 0);
        chk({tag, "_adrs_mem"}, Adrs_MEM, 0);
        chk({tag, "_state_idle"}, 32'(dbg_state == ST_IDLE), 1);
    endtask

    task automatic reset_mid_access();
        vec_t r;
        r = mk(32'h500, 0, 5'd7, 1, 1, 1, 0, 0, 0, 5, 32'h1234_5678);
        drive_exe(r); dmem_ack = 0;
        @(posedge Clk); #1;
        drive_exe(nop);
        @(negedge Clk);
        chk("rst_pre_req", 32'(dmem_req), 1);
        chk("rst_pre_stall", 32'(Mem_stall), 1);
        Rst = 1;
        @(posedge Clk); #1;
        Rst = 0; dmem_ack = 1; dmem_rdata = 32'hBAD0_BAD0;
        @(negedge Clk);
        check_all_zero("rst_mid");
        @(posedge Clk); #1;
        dmem_ack = 0;
        @(negedge Clk);
        check_all_zero("rst_late_ack");
        @(posedge Clk); #1;
        exp_q.delete();
        exp_q.push_back(BUBBLE);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        nop = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        Rst = 1; dmem_ack = 0; dmem_rdata = 0;
        drive_exe(nop);

        tab[0]  = with_exp(mk(32'h100, 0, 8, 1, 1, 1, 0, 0, 0, 0, 32'hDEAD_BEEF),
                           32'h100, 4'b1111, 0, 32'hDEAD_BEEF, 1, 0);
        tab[1]  = with_exp(mk(32'h203, 32'h1234_5678, 0, 0, 0, 0, 1, 1, 0, 0, 0),
                           32'h200, 4'b0001, 32'h7878_7878, 32'h203, 0, 0);
        tab[2]  = with_exp(mk(32'h101, 0, 3, 1, 1, 1, 0, 1, 0, 0, 32'h00F0_0000),
                           32'h100, 4'b0100, 0, 32'hFFFF_FFF0, 1, 0);
        tab[3]  = with_exp(mk(32'h101, 0, 3, 1, 1, 1, 0, 1, 1, 0, 32'h00F0_0000),
                           32'h100, 4'b0100, 0, 32'h0000_00F0, 1, 0);
        tab[4]  = with_exp(mk(32'h2C, 0, 9, 1, 1, 1, 0, 0, 0, 3, 32'hCAFE_F00D),
                           32'h2C, 4'b1111, 0, 32'hCAFE_F00D, 1, 0);
        tab[5]  = with_exp(mk(32'h102, 32'h1111_1111, 0, 0, 0, 0, 1, 0, 0, 0, 0),
                           0, 0, 0, 32'h102, 0, 1);
        tab[6]  = with_exp(mk(32'h0FE, 0, 4, 1, 1, 1, 0, 0, 0, 0, 32'h5555_5555),
                           0, 0, 0, 0, 0, 1);
        tab[7]  = with_exp(mk(32'h203, 0, 10, 1, 1, 1, 0, 1, 1, 0, 32'h0000_00A5),
                           32'h200, 4'b0001, 0, 32'h0000_00A5, 1, 0);
        tab[8]  = with_exp(mk(32'h300, 0, 11, 1, 1, 1, 0, 1, 0, 1, 32'h8012_3456),
                           32'h300, 4'b1000, 0, 32'hFFFF_FF80, 1, 0);
        tab[9]  = with_exp(mk(32'h400, 32'hA5A5_0F0F, 0, 0, 0, 0, 1, 0, 0, 1, 0),
                           32'h400, 4'b1111, 32'hA5A5_0F0F, 32'h400, 0, 0);
        tab[10] = with_exp(mk(32'h1234, 0, 5, 1, 0, 0, 0, 0, 0, 0, 0),
                           0, 0, 0, 32'h1234, 1, 0);

        repeat (3) @(posedge Clk);
        @(negedge Clk);
        check_all_zero("reset");
        @(posedge Clk); #1;
        Rst = 0;
        exp_q.push_back(BUBBLE);
        cur = nop;

        for (int i = 0; i < 11; i++) begin
            step(cur, tab[i]);
            cur = tab[i];
        end
        step(cur, nop);
        cur = nop;

        for (int i = 0; i < 300; i++) begin
            v = rand_vec();
            step(cur, v);
            cur = v;
        end
        step(cur, nop);
        step(nop, nop);

        reset_mid_access();
        cur = nop;
        for (int i = 0; i < 60; i++) begin
            v = rand_vec();
            step(cur, v);
            cur = v;
        end
        step(cur, nop);
        step(nop, nop);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
